// File: rtl/paint_pkg.sv
// Shared definitions for the brush stroke painter.
//   brush_state_t : stroke controller FSM states
//   KEY_*         : USB keycodes the painter reacts to
//   COLOR_W       : width of a pixel colour index
//   COORD_W       : width of the signed scan coordinates
//   key_color()   : maps a colour-select keycode to its colour index
package paint_pkg;

   localparam int unsigned COLOR_W = 4;
   localparam int unsigned COORD_W = 11;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_1     = 8'h1E;
   localparam logic [7:0] KEY_2     = 8'h1F;
   localparam logic [7:0] KEY_3     = 8'h20;
   localparam logic [7:0] KEY_4     = 8'h21;
   localparam logic [7:0] KEY_E     = 8'h08;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StScan,
      StReq,
      StDone
   } brush_state_t;

   // Keys 1..4 select colours 1..4; any other key keeps the current colour.
   function automatic logic [COLOR_W-1:0] key_color(input logic [7:0]         key,
                                                    input logic [COLOR_W-1:0] cur);
      logic [COLOR_W-1:0] res;
      res = cur;
      case (key)
         KEY_1:   res = COLOR_W'(1);
         KEY_2:   res = COLOR_W'(2);
         KEY_3:   res = COLOR_W'(3);
         KEY_4:   res = COLOR_W'(4);
         default: res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/brush_scan_counter.sv
// Row-major scan counters for one brush stroke.
// Walks y from cy-S to cy+S (outer) and x from cx-S to cx+S (inner) as signed
// 11-bit values so that pixels left of / above the screen stay representable.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   load                : capture centre and size, point at the first pixel
//   center_x, center_y  : stroke centre (unsigned pixel coordinates)
//   size                : brush half-size S (already clamped by the caller)
//   advance             : step to the next pixel in scan order
//   cur_x, cur_y        : current scan coordinate (signed)
//   in_range            : current coordinate lies on screen
//   last                : current coordinate is the final pixel of the stroke
module brush_scan_counter
   import paint_pkg::*;
#(
   parameter int unsigned X_MAX = 639,
   parameter int unsigned Y_MAX = 479
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      load,
   input  logic [9:0]                center_x,
   input  logic [9:0]                center_y,
   input  logic [9:0]                size,
   input  logic                      advance,
   output logic signed [COORD_W-1:0] cur_x,
   output logic signed [COORD_W-1:0] cur_y,
   output logic                      in_range,
   output logic                      last
);

   localparam logic signed [COORD_W-1:0] XLim = COORD_W'(X_MAX);
   localparam logic signed [COORD_W-1:0] YLim = COORD_W'(Y_MAX);

   logic signed [COORD_W-1:0] x_q, y_q;
   logic signed [COORD_W-1:0] x_first_q, x_last_q, y_last_q;
   logic signed [COORD_W-1:0] cx_s, cy_s, size_s;

   // Zero-extend into the signed domain before subtracting the half-size.
   assign cx_s   = signed'({1'b0, center_x});
   assign cy_s   = signed'({1'b0, center_y});
   assign size_s = signed'({1'b0, size});

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q       <= '0;
         y_q       <= '0;
         x_first_q <= '0;
         x_last_q  <= '0;
         y_last_q  <= '0;
      end else if (load) begin
         x_q       <= cx_s - size_s;
         y_q       <= cy_s - size_s;
         x_first_q <= cx_s - size_s;
         x_last_q  <= cx_s + size_s;
         y_last_q  <= cy_s + size_s;
      end else if (advance) begin
         if (x_q == x_last_q) begin
            x_q <= x_first_q;
            y_q <= y_q + 11'sd1;
         end else begin
            x_q <= x_q + 11'sd1;
         end
      end
   end

   assign cur_x    = x_q;
   assign cur_y    = y_q;
   assign last     = (x_q == x_last_q) && (y_q == y_last_q);
   assign in_range = !x_q[COORD_W-1] && !y_q[COORD_W-1] && (x_q <= XLim) && (y_q <= YLim);

endmodule

// File: rtl/brush_stroke_ctrl.sv
// Brush stroke controller: on a frame tick with the space key held, paints a
// (2S+1)x(2S+1) square of pixels around the cursor through a req/ack pixel
// write port, skipping pixels that fall off screen.
// Build option: define BRUSH_ERASE_EN to let keycode 8'h08 select colour 0 (erase).
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   frame_tick           : one-cycle pulse per video frame
//   keycode              : current USB keycode
//   BallX, BallY, BallS  : cursor centre and requested brush half-size
//   wr_req, wr_ack       : pixel write handshake (req held until ack)
//   wr_x, wr_y, wr_color : pixel write address and colour
//   busy                 : stroke in progress
//   stroke_done          : one-cycle pulse when a stroke completes
//   drop_cnt             : saturating count of frame ticks ignored while busy
module brush_stroke_ctrl
   import paint_pkg::*;
#(
   parameter int unsigned X_MAX     = 639,
   parameter int unsigned Y_MAX     = 479,
   parameter int unsigned BRUSH_MAX = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic [7:0]         keycode,
   input  logic [9:0]         BallX,
   input  logic [9:0]         BallY,
   input  logic [9:0]         BallS,
   output logic               wr_req,
   input  logic               wr_ack,
   output logic [9:0]         wr_x,
   output logic [9:0]         wr_y,
   output logic [COLOR_W-1:0] wr_color,
   output logic               busy,
   output logic               stroke_done,
   output logic [7:0]         drop_cnt
);

   localparam logic [9:0] SizeMax = 10'(BRUSH_MAX);

   brush_state_t state_q, state_d;

   logic [COLOR_W-1:0] color_q, color_d;
   logic [COLOR_W-1:0] stroke_color_q;
   logic [COLOR_W-1:0] wr_color_q;
   logic [9:0]         wr_x_q, wr_y_q;
   logic [7:0]         drop_cnt_q;

   logic                      scan_load, scan_adv, issue;
   logic [9:0]                size_clamp;
   logic signed [COORD_W-1:0] cur_x, cur_y;
   logic                      in_range, last;
   logic                      coord_sign_unused;

   assign size_clamp = (BallS > SizeMax) ? SizeMax : BallS;

   brush_scan_counter #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
   ) u_scan (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (scan_load),
      .center_x (BallX),
      .center_y (BallY),
      .size     (size_clamp),
      .advance  (scan_adv),
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .in_range (in_range),
      .last     (last)
   );

   // Only on-screen coordinates are forwarded, so the sign bits never matter here.
   assign coord_sign_unused = cur_x[COORD_W-1] ^ cur_y[COORD_W-1];

   // Colour register follows the colour keys on every cycle, stroke or not.
   always_comb begin
      color_d = key_color(keycode, color_q);
`ifdef BRUSH_ERASE_EN
      if (keycode == KEY_E) begin
         color_d = '0;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      scan_load = 1'b0;
      scan_adv  = 1'b0;
      issue     = 1'b0;
      case (state_q)
         StIdle: begin
            if (frame_tick && (keycode == KEY_SPACE)) begin
               state_d = StLatch;
            end
         end
         StLatch: begin
            scan_load = 1'b1;
            state_d   = StScan;
         end
         StScan: begin
            if (in_range) begin
               issue   = 1'b1;
               state_d = StReq;
            end else if (last) begin
               state_d = StDone;
            end else begin
               scan_adv = 1'b1;
            end
         end
         StReq: begin
            // Returning through StScan guarantees a low cycle on wr_req between pixels.
            if (wr_ack) begin
               if (last) begin
                  state_d = StDone;
               end else begin
                  scan_adv = 1'b1;
                  state_d  = StScan;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q        <= StIdle;
         color_q        <= COLOR_W'(1);
         stroke_color_q <= COLOR_W'(1);
         wr_x_q         <= '0;
         wr_y_q         <= '0;
         wr_color_q     <= '0;
         drop_cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         if (scan_load) begin
            stroke_color_q <= color_q;
         end
         if (issue) begin
            wr_x_q     <= cur_x[9:0];
            wr_y_q     <= cur_y[9:0];
            wr_color_q <= stroke_color_q;
         end
         if (frame_tick && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign wr_req      = (state_q == StReq);
   assign wr_x        = wr_x_q;
   assign wr_y        = wr_y_q;
   assign wr_color    = wr_color_q;
   assign busy        = (state_q != StIdle);
   assign stroke_done = (state_q == StDone);
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_brush_stroke_ctrl.sv
// Scoreboard bench for brush_stroke_ctrl: strokes push expected pixel writes,
// a negedge monitor pops and compares whenever wr_req rises.
module tb_brush_stroke_ctrl;
   import paint_pkg::*;

   logic               Clk = 1'b0;
   logic               Reset;
   logic               frame_tick;
   logic [7:0]         keycode;
   logic [9:0]         BallX, BallY, BallS;
   logic               wr_req;
   logic               wr_ack;
   logic [9:0]         wr_x, wr_y;
   logic [COLOR_W-1:0] wr_color;
   logic               busy, stroke_done;
   logic [7:0]         drop_cnt;

   always #5 Clk = ~Clk;

   brush_stroke_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_tick  (frame_tick),
      .keycode     (keycode),
      .BallX       (BallX),
      .BallY       (BallY),
      .BallS       (BallS),
      .wr_req      (wr_req),
      .wr_ack      (wr_ack),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_color    (wr_color),
      .busy        (busy),
      .stroke_done (stroke_done),
      .drop_cnt    (drop_cnt)
   );

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   pix_t exp_q[$];
   pix_t acc_q[$];
   int   vectors    = 0;
   int   errors     = 0;
   int   ack_delay  = 0;
   int   wait_cnt   = 0;
   int   done_count = 0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: scoreboard compare on wr_req rise, hold checks while it stays high.
   initial begin
      logic       prev_req;
      logic       prev_done;
      logic [9:0] hold_x, hold_y;
      logic [3:0] hold_c;
      pix_t       e;
      prev_req  = 1'b0;
      prev_done = 1'b0;
      hold_x = '0; hold_y = '0; hold_c = '0;
      forever begin
         @(negedge Clk);
         if (Reset !== 1'b1) begin
            if (wr_req && !prev_req) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_x", int'(wr_x), e.x);
                  check("wr_y", int'(wr_y), e.y);
                  check("wr_color", int'(wr_color), e.c);
               end
               hold_x = wr_x;
               hold_y = wr_y;
               hold_c = wr_color;
            end else if (wr_req && prev_req) begin
               check("hold_x", int'(wr_x), int'(hold_x));
               check("hold_y", int'(wr_y), int'(hold_y));
               check("hold_color", int'(wr_color), int'(hold_c));
            end
            if (stroke_done) begin
               check("done_width", int'(prev_done), 0);
               check("done_pending", exp_q.size(), 0);
               done_count++;
            end
         end
         prev_req  = wr_req;
         prev_done = stroke_done;
      end
   end

   // Ack responder: raise wr_ack ack_delay cycles after wr_req is seen.
   initial begin
      wr_ack = 1'b0;
      forever begin
         @(negedge Clk);
         if (wr_req && !wr_ack && (Reset !== 1'b1)) begin
            if (wait_cnt >= ack_delay) begin
               wr_ack   = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wr_ack   = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Log of accepted writes, in order.
   initial begin
      pix_t p;
      forever begin
         @(posedge Clk);
         if ((Reset !== 1'b1) && wr_req && wr_ack) begin
            p.x = int'(wr_x);
            p.y = int'(wr_y);
            p.c = int'(wr_color);
            acc_q.push_back(p);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic expect_stroke(input int bx, input int by, input int bs, input int c);
      int   s;
      pix_t p;
      s = (bs > 8) ? 8 : bs;
      for (int yy = by - s; yy <= by + s; yy++) begin
         for (int xx = bx - s; xx <= bx + s; xx++) begin
            if (xx >= 0 && xx <= 639 && yy >= 0 && yy <= 479) begin
               p.x = xx;
               p.y = yy;
               p.c = c;
               exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic start_stroke(input int bx, input int by, input int bs, input int c);
      @(negedge Clk);
      BallX = 10'(bx);
      BallY = 10'(by);
      BallS = 10'(bs);
      expect_stroke(bx, by, bs, c);
      keycode    = KEY_SPACE;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      keycode    = 8'h00;
   endtask

   task automatic wait_done(input string name, input int budget);
      int start;
      int n;
      start = done_count;
      n     = 0;
      while (done_count == start && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (done_count == start) begin
         check(name, 0, 1);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic press_key(input logic [7:0] k);
      @(negedge Clk);
      keycode = k;
      @(negedge Clk);
      keycode = 8'h00;
   endtask

   task automatic check_ends(input string name, input int base, input int cnt,
                             input int fx, input int fy, input int lx, input int ly);
      check({name, "_count"}, acc_q.size() - base, cnt);
      if (acc_q.size() > base) begin
         check({name, "_first_x"}, acc_q[base].x, fx);
         check({name, "_first_y"}, acc_q[base].y, fy);
         check({name, "_last_x"}, acc_q[acc_q.size()-1].x, lx);
         check({name, "_last_y"}, acc_q[acc_q.size()-1].y, ly);
      end
   endtask

   initial begin
      int base;
      int n;
      Reset      = 1'b1;
      frame_tick = 1'b0;
      keycode    = 8'h00;
      BallX      = '0;
      BallY      = '0;
      BallS      = '0;
      repeat (2) @(negedge Clk);
      check("rst_wr_req", int'(wr_req), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(stroke_done), 0);
      check("rst_drop", int'(drop_cnt), 0);
      check("rst_wr_x", int'(wr_x), 0);
      check("rst_wr_color", int'(wr_color), 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      // A tick without space must not start a stroke.
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      @(negedge Clk);
      check("no_space_busy", int'(busy), 0);

      // Test 1: 3x3 centred stroke.
      base = acc_q.size();
      start_stroke(320, 240, 1, 1);
      check("t1_busy", int'(busy), 1);
      wait_done("t1_timeout", 200);
      check_ends("t1", base, 9, 319, 239, 321, 241);
      check("t1_idle", int'(busy), 0);

      // Test 2: corner stroke, 16 pixels clipped.
      base = acc_q.size();
      start_stroke(0, 0, 2, 1);
      wait_done("t2_timeout", 200);
      check_ends("t2", base, 9, 0, 0, 2, 2);

      // Test 3: oversize brush clamps to 8.
      base = acc_q.size();
      start_stroke(320, 240, 20, 1);
      wait_done("t3_timeout", 2000);
      check_ends("t3", base, 289, 312, 232, 328, 248);

      // Test 4: slow ack with ticks arriving mid-stroke.
      ack_delay = 50;
      base = acc_q.size();
      start_stroke(100, 100, 0, 1);
      repeat (10) @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1;
         @(negedge Clk);
         frame_tick = 1'b0;
         repeat (5) @(negedge Clk);
      end
      wait_done("t4_timeout", 300);
      ack_delay = 0;
      check("t4_drop_cnt", int'(drop_cnt), 3);
      check_ends("t4", base, 1, 100, 100, 100, 100);

      // Test 5: reset after the 4th of 9 writes; stroke painted in colour 4.
      press_key(KEY_4);
      base = acc_q.size();
      start_stroke(50, 50, 1, 4);
      n = 0;
      while ((acc_q.size() - base) < 4 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      check("t5_reach_4", acc_q.size() - base, 4);
      Reset = 1'b1;
      exp_q.delete();
      @(negedge Clk);
      check("t5_wr_req", int'(wr_req), 0);
      check("t5_busy", int'(busy), 0);
      check("t5_drop", int'(drop_cnt), 0);
      check("t5_done", int'(stroke_done), 0);
      check("t5_wr_color", int'(wr_color), 0);
      Reset = 1'b0;
      repeat (30) @(negedge Clk);
      check("t5_no_more_writes", acc_q.size() - base, 4);
      // Colour register back to 1 after reset.
      base = acc_q.size();
      start_stroke(5, 5, 0, 1);
      wait_done("t5b_timeout", 100);
      check_ends("t5b", base, 1, 5, 5, 5, 5);

      // Test 6: colour 3 stroke; a mid-stroke key change must not leak in.
      press_key(KEY_3);
      base = acc_q.size();
      start_stroke(200, 100, 1, 3);
      repeat (4) @(negedge Clk);
      keycode = KEY_1;
      @(negedge Clk);
      keycode = 8'h00;
      wait_done("t6_timeout", 200);
      check_ends("t6", base, 9, 199, 99, 201, 101);

      // Erase key: colour 0 when enabled, otherwise the colour stays 1.
      press_key(KEY_E);
      base = acc_q.size();
`ifdef BRUSH_ERASE_EN
      start_stroke(300, 200, 0, 0);
`else
      start_stroke(300, 200, 0, 1);
`endif
      wait_done("t6e_timeout", 100);
      check_ends("t6e", base, 1, 300, 200, 300, 200);
      check("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/brush_stroke_ctrl.md
BRUSH_STROKE_CTRL -- requirements
Module: brush_stroke_ctrl

Interface
REQ-001 The block SHALL have parameter X_MAX, default 639, rightmost legal pixel column.
REQ-002 The block SHALL have parameter Y_MAX, default 479, bottommost legal pixel row.
REQ-003 The block SHALL have parameter BRUSH_MAX, default 8, maximum brush half-size in pixels.
REQ-004 The block SHALL have port Clk, input, 1, sole clock; one clock, all state on rising edge.
REQ-005 The block SHALL have port Reset, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port frame_tick, input, 1, one-Clk pulse per video frame.
REQ-007 The block SHALL have port keycode, input, 8, current USB keycode.
REQ-008 The block SHALL have ports BallX and BallY, input, 10 each, cursor centre.
REQ-009 The block SHALL have port BallS, input, 10, requested brush half-size.
REQ-010 The block SHALL have ports wr_req (output, 1) and wr_ack (input, 1), pixel-write handshake.
REQ-011 The block SHALL have outputs wr_x and wr_y, 10 each, pixel address.
REQ-012 The block SHALL have output wr_color, 4, pixel colour index.
REQ-013 The block SHALL have outputs busy (1, stroke in progress), stroke_done (1, one-cycle pulse) and drop_cnt (8, dropped ticks).

Function
REQ-014 The FSM SHALL have states IDLE, LATCH, SCAN, REQ and DONE.
REQ-015 In IDLE, frame_tick=1 with keycode=8'h2C (space) SHALL go to LATCH; any other frame_tick SHALL stay in IDLE.
REQ-016 LATCH SHALL capture BallX, BallY, colour and S=min(BallS,BRUSH_MAX), then go to SCAN. This takes 1 cycle.
REQ-017 The scan SHALL be row-major: y from Y-S to Y+S (outer), x from X-S to X+S (inner); S=0 SHALL give exactly one pixel.
REQ-018 Scan coordinates SHALL be computed as 11-bit signed values; a coordinate <0, >X_MAX or >Y_MAX SHALL be skipped in SCAN, one cycle per skip, with no wr_req.
REQ-019 An in-range pixel SHALL go SCAN->REQ; wr_req SHALL rise on the next edge with stable wr_x/wr_y/wr_color.
REQ-020 wr_req and its address and colour SHALL be held unchanged until wr_ack is sampled high.
REQ-021 On a sampled wr_ack the scan SHALL advance; wr_req SHALL be low for at least one cycle between pixels.
REQ-022 After the last pixel (write acked, or skipped), the FSM SHALL enter DONE; stroke_done SHALL pulse one cycle, then return to IDLE.
REQ-023 wr_ack while wr_req=0 SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A frame_tick while busy=1 SHALL be dropped and drop_cnt incremented, saturating at 255.
REQ-026 Keycodes 8'h1E/1F/20/21 SHALL set the colour register to 1/2/3/4 on any cycle; a change mid-stroke SHALL not affect the latched stroke colour.
REQ-027 BallX/BallY/BallS changes during a stroke SHALL be ignored until the next LATCH.

Reset
REQ-028 Reset SHALL on the next edge force: state IDLE, wr_req=0, wr_x=0, wr_y=0, wr_color=0, busy=0, stroke_done=0, drop_cnt=0, colour register=1.
REQ-029 Reset asserted mid-stroke SHALL abandon the stroke; no further wr_req SHALL be issued for it.

Configuration
REQ-030 With BRUSH_ERASE_EN defined, keycode 8'h08 (E) SHALL set the colour register to 0 (erase).
REQ-031 Without BRUSH_ERASE_EN, 8'h08 SHALL have no effect and colour 0 SHALL never be emitted after reset.

Structure
REQ-032 Package paint_pkg SHALL hold the FSM state enum, the keycode constants (space, 1-4, E) and the COLOR_W=4 constant.
REQ-033 Sub-module brush_scan_counter SHALL hold the signed x/y scan counters, exposing cur_x, cur_y, in_range, advance and last.

Verification
REQ-034 Test 1: Ball=(320,240), BallS=1, space+tick, ack 1 cycle after each req -> 9 writes from (319,239) to (321,241) row-major, then one stroke_done.
REQ-035 Test 2: Ball=(0,0), BallS=2 -> only 9 writes, (0..2,0..2); 16 clipped pixels, no req for them.
REQ-036 Test 3: BallS=20 -> S clamped to 8, 289 writes.
REQ-037 Test 4: hold wr_ack low 50 cycles with 3 ticks meanwhile -> wr_req/address stable throughout; drop_cnt=3.
REQ-038 Test 5: Reset after 4th write of 9 -> wr_req low next edge, busy=0, no further writes, colour=1.
REQ-039 Test 6: keycode 8'h20 then stroke -> all wr_color=3; with BRUSH_ERASE_EN, 8'h08 -> wr_color=0.
